// File: rtl/mpt_walk_mem_arbiter.sv
// Round-robin arbiter serialising MPTE fetches from NUM_REQ walk stages onto one memory read port.
// Optional WAIT watchdog with stray-response drain: define MPT_ARB_TIMEOUT_EN.
module mpt_walk_mem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    input  logic                          mem_valid_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

    state_t                  r_state, w_state_nxt;
    logic [PTR_W-1:0]        r_rr_ptr, r_idx;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;

    logic [PTR_W-1:0]        w_win_idx, w_hi_idx, w_lo_idx, w_ptr_nxt;
    logic                    w_hi_any, w_win_found, w_accept, w_rsp_hs, w_timeout;
    logic [ADDR_WIDTH-1:0]   w_win_addr;

    // Requesters at or above the pointer take precedence; otherwise wrap to the lowest one.
    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        w_hi_any = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid_i[j]) begin
                w_lo_idx = PTR_W'(j);
                if (PTR_W'(j) >= r_rr_ptr) begin
                    w_hi_idx = PTR_W'(j);
                    w_hi_any = 1'b1;
                end
            end
        end
        w_win_idx   = w_hi_any ? w_hi_idx : w_lo_idx;
        w_win_found = |req_valid_i;
    end

    always_comb begin
        w_win_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win_idx == PTR_W'(k)) w_win_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign w_ptr_nxt = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

`ifdef MPT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err, r_drain;

    assign w_accept  = (r_state == S_IDLE) && w_win_found && !r_drain;
    assign w_timeout = (r_state == S_WAIT) && !mem_valid_i && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err_o = r_err;

    // A timed-out read may still return later; drain swallows that one late beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_drain <= 1'b0;
        end else begin
            if (r_state == S_ISSUE && mem_gnt_i) r_cnt <= '0;
            else if (r_state == S_WAIT)          r_cnt <= r_cnt + 1'b1;
            if (r_drain && mem_valid_i) r_drain <= 1'b0;
            if (w_timeout) begin
                r_err   <= 1'b1;
                r_drain <= 1'b1;
            end else if (r_state == S_DELIVER && w_rsp_hs) begin
                r_err   <= 1'b0;
            end
        end
    end
`else
    assign w_accept  = (r_state == S_IDLE) && w_win_found;
    assign w_timeout = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready_o[k] = w_accept && (w_win_idx == PTR_W'(k));
            rsp_valid_o[k] = (r_state == S_DELIVER) && (r_idx == PTR_W'(k));
        end
    end

    assign w_rsp_hs   = |(rsp_valid_o & rsp_ready_i);
    assign mem_req_o  = (r_state == S_ISSUE);
    assign mem_addr_o = r_addr;
    assign rsp_data_o = r_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept)                   w_state_nxt = S_ISSUE;
            S_ISSUE:   if (mem_gnt_i)                  w_state_nxt = S_WAIT;
            S_WAIT:    if (mem_valid_i || w_timeout)   w_state_nxt = S_DELIVER;
            S_DELIVER: if (w_rsp_hs)                   w_state_nxt = S_IDLE;
            default:                                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_idx    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            if (w_accept) begin
                r_idx  <= w_win_idx;
                r_addr <= w_win_addr;
            end
            if (r_state == S_WAIT && mem_valid_i) r_data <= mem_rdata_i;
            else if (w_timeout)                   r_data <= '0;
            if (r_state == S_DELIVER && w_rsp_hs) r_rr_ptr <= w_ptr_nxt;
        end
    end
endmodule

// File: tb/tb_mpt_walk_mem_arbiter.sv
// Directed bench for mpt_walk_mem_arbiter: a transaction-level scoreboard checks every cycle,
// literal expectations pin the latency, grant order, hold and reset behaviour.
`timescale 1ns/1ps
module tb_mpt_walk_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    rsp_ready_i = '0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic            mem_gnt_i = 1'b0;
    logic            mem_valid_i = 1'b0;
    logic [DW-1:0]   mem_rdata_i = '0;
    logic [N-1:0]    req_ready_o, rsp_valid_o;
    logic [DW-1:0]   rsp_data_o;
    logic            rsp_err_o, mem_req_o;
    logic [AW-1:0]   mem_addr_o;

    mpt_walk_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int glog[$];
    int exp2[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Transaction scoreboard: one open record from acceptance until response handshake.
    bit          m_busy, m_gnt, m_have, m_err, m_drain;
    int          m_idx, m_ptr, m_wcnt;
    logic [63:0] m_addr, m_data;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rsp;
        int           w;
        if (!rst_ni) begin
            m_busy = 0; m_gnt = 0; m_have = 0; m_err = 0; m_drain = 0;
            m_idx = 0; m_ptr = 0; m_wcnt = 0;
            chk("rst req_ready", req_ready_o, 0);
            chk("rst rsp_valid", rsp_valid_o, 0);
            chk("rst mem_req", mem_req_o, 0);
            chk("rst rsp_err", rsp_err_o, 0);
            chk("rst mem_addr", mem_addr_o, 0);
            chk("rst rsp_data", rsp_data_o, 0);
        end else begin
            w = (m_busy || m_drain) ? -1 : rr_pick(m_ptr, req_valid_i);
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            exp_rsp = '0;
            if (m_busy && m_have) exp_rsp[m_idx] = 1'b1;
            chk("req_ready", req_ready_o, exp_rdy);
            chk("mem_req", mem_req_o, m_busy && !m_gnt);
            if (m_busy && !m_gnt) chk("mem_addr", mem_addr_o, m_addr);
            chk("rsp_valid", rsp_valid_o, exp_rsp);
            chk("rsp_err", rsp_err_o, m_busy && m_have && m_err);
            if (m_busy && m_have) chk("rsp_data", rsp_data_o, m_data);

            if (m_drain && mem_valid_i) m_drain = 0;
            if (w >= 0) begin
                m_busy = 1; m_gnt = 0; m_have = 0; m_err = 0;
                m_idx = w; m_addr = req_addr_i[w*AW +: AW];
                glog.push_back(w);
            end else if (m_busy && !m_gnt) begin
                if (mem_gnt_i) begin m_gnt = 1; m_wcnt = 0; end
            end else if (m_busy && !m_have) begin
                if (mem_valid_i) begin
                    m_have = 1; m_data = mem_rdata_i;
                end
`ifdef MPT_ARB_TIMEOUT_EN
                else begin
                    m_wcnt++;
                    if (m_wcnt == TO) begin
                        m_have = 1; m_err = 1; m_data = 0; m_drain = 1;
                    end
                end
`endif
            end else if (m_busy && rsp_ready_i[m_idx]) begin
                m_busy = 0;
                m_ptr  = (m_idx + 1) % N;
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic neg(); @(negedge clk); endtask
    task automatic set_addr(input int i, input logic [63:0] a); req_addr_i[i*AW +: AW] = a; endtask

    task automatic do_reset();
        tick();
        req_valid_i = '0; rsp_ready_i = '0; mem_gnt_i = 0; mem_valid_i = 0;
        rst_ni = 0;
        tick(); tick();
        rst_ni = 1;
    endtask

    // Wait for a memory request, grant after gdly cycles, return data one cycle later.
    task automatic serve(input logic [63:0] d, input int gdly);
        int n;
        n = 0;
        while (!mem_req_o && n < 50) begin tick(); n++; end
        chk("serve mem_req seen", mem_req_o, 1);
        repeat (gdly) tick();
        mem_gnt_i = 1; tick();
        mem_gnt_i = 0; mem_valid_i = 1; mem_rdata_i = d; tick();
        mem_valid_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 100000", $time);
        $fatal(1);
    end

    initial begin
        int cnt;
        tick(); tick();
        rst_ni = 1;

        // 1: single request, latency 0->3
        set_addr(0, 64'h8000_1000); req_valid_i = 4'b0001; rsp_ready_i = 4'b0001;
        neg(); chk("t1 c0 accept", req_ready_o, 4'b0001); chk("t1 c0 mem_req", mem_req_o, 0);
        tick(); req_valid_i = 0; mem_gnt_i = 1;
        neg(); chk("t1 c1 mem_req", mem_req_o, 1); chk("t1 c1 mem_addr", mem_addr_o, 64'h8000_1000);
        tick(); mem_gnt_i = 0; mem_valid_i = 1; mem_rdata_i = 64'hDEAD_BEEF_0000_0001;
        neg(); chk("t1 c2 rsp_valid", rsp_valid_o, 0);
        tick(); mem_valid_i = 0;
        neg(); chk("t1 c3 rsp_valid", rsp_valid_o, 4'b0001);
        chk("t1 c3 rsp_data", rsp_data_o, 64'hDEAD_BEEF_0000_0001);
        tick(); rsp_ready_i = 0;
        neg(); chk("t1 c4 rsp_valid", rsp_valid_o, 0);

        // 2: all stages requesting continuously
        do_reset();
        glog.delete();
        for (int i = 0; i < N; i++) set_addr(i, 64'h1000 * (i + 1));
        req_valid_i = '1; rsp_ready_i = '1;
        for (int t = 0; t < 5; t++) serve(64'hA5A5_0000_0000_0000 + 64'(t), 0);
        req_valid_i = 0;
        tick(); tick();
        chk("t2 grant count", glog.size(), 5);
        for (int t = 0; t < 5; t++) chk("t2 grant order", (t < glog.size()) ? glog[t] : -1, exp2[t]);

        // 3: grant held off 5 cycles
        set_addr(1, 64'h8000_2040); req_valid_i = 4'b0010;
        tick(); req_valid_i = 0;
        cnt = 0;
        repeat (5) begin
            neg(); if (mem_req_o) cnt++;
            chk("t3 addr hold", mem_addr_o, 64'h8000_2040);
            tick();
        end
        mem_gnt_i = 1;
        neg(); if (mem_req_o) cnt++;
        tick(); mem_gnt_i = 0; mem_valid_i = 1; mem_rdata_i = 64'h0000_0000_CAFE_0003;
        chk("t3 req cycles", cnt, 6);
        neg(); chk("t3 wait mem_req", mem_req_o, 0);
        tick(); mem_valid_i = 0;
        neg(); chk("t3 rsp_valid", rsp_valid_o, 4'b0010);
        tick();

        // 4: response back-pressure on stage 2, others' ready ignored
        rsp_ready_i = 0; set_addr(2, 64'h8000_3000); req_valid_i = 4'b0100;
        serve(64'h0123_4567_89AB_CDEF, 0);
        rsp_ready_i = 4'b1011; req_valid_i = 4'b1011;
        repeat (4) begin
            neg();
            chk("t4 rsp_valid hold", rsp_valid_o, 4'b0100);
            chk("t4 rsp_data hold", rsp_data_o, 64'h0123_4567_89AB_CDEF);
            chk("t4 no accept", req_ready_o, 0);
            tick();
        end
        rsp_ready_i = 4'b0100;
        tick(); rsp_ready_i = 0;
        neg(); chk("t4 b2b accept", req_ready_o, 4'b1000);

        // 5: reset during WAIT, late memory data afterwards
        tick(); req_valid_i = 0;
        mem_gnt_i = 1; tick(); mem_gnt_i = 0;
        rst_ni = 0;
        neg(); chk("t5 rsp in rst", rsp_valid_o, 0);
        tick(); rst_ni = 1; mem_valid_i = 1; mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (3) begin
            neg(); chk("t5 no rsp", rsp_valid_o, 0); chk("t5 no mem_req", mem_req_o, 0);
            tick(); mem_valid_i = 0;
        end
        req_valid_i = '1; rsp_ready_i = '1;
        neg(); chk("t5 ptr reset", req_ready_o, 4'b0001);
        tick(); req_valid_i = 0;
        serve(64'h5555_AAAA_5555_AAAA, 0);
        tick();

`ifdef MPT_ARB_TIMEOUT_EN
        // 6: watchdog timeout, stray late beat drained
        set_addr(0, 64'h8000_4000); req_valid_i = 4'b0001;
        tick(); req_valid_i = 0; mem_gnt_i = 1;
        tick(); mem_gnt_i = 0;
        repeat (TO) begin
            neg(); chk("t6 waiting", rsp_valid_o, 0);
            tick();
        end
        neg(); chk("t6 rsp_valid", rsp_valid_o, 4'b0001);
        chk("t6 rsp_err", rsp_err_o, 1); chk("t6 rsp_data", rsp_data_o, 0);
        tick(); req_valid_i = 4'b0010;
        neg(); chk("t6 drain blocks", req_ready_o, 0);
        tick(); mem_valid_i = 1; mem_rdata_i = 64'hFFFF_0000_FFFF_0000;
        neg(); chk("t6 drain blocks 2", req_ready_o, 0);
        tick(); mem_valid_i = 0;
        neg(); chk("t6 resume", req_ready_o, 4'b0010);
        tick(); req_valid_i = 0;
        serve(64'h7777_0000_7777_0000, 0);
        neg(); chk("t6 normal err", rsp_err_o, 0);
        tick();
`endif

        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
